ltc5548_pio_poll_master: RTL and testbench



---
 rtl/ltc5548_pio_poll_master_if.sv | 9 +
 rtl/ltc5548_pio_poll_master.sv | 141 ++++++++++++++
 tb/tb_ltc5548_pio_poll_master.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ltc5548_pio_poll_master_if.sv
// ltc5548_pio_poll_master_if: Avalon-MM read channel between the poller and the LTC5548 PIO slave
interface ltc5548_pio_poll_master_if;
  logic [1:0]  address;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;
  modport master (output address, read, input readdata, waitrequest);
  modport slave  (input address, read, output readdata, waitrequest);
endinterface

// File: rtl/ltc5548_pio_poll_master.sv
// ltc5548_pio_poll_master: periodic Avalon-MM poller of the LTC5548 PIO with sample stream and window average
// Optional window min/max tracking is built when LTC5548_POLL_MINMAX_EN is defined; otherwise win_min/win_max are 0.
module ltc5548_pio_poll_master #(
  parameter int DATA_W       = 12,
  parameter int POLL_DIV     = 1000,
  parameter int READ_LATENCY = 1,
  parameter int AVG_LOG2     = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  ltc5548_pio_poll_master_if.master  avm,
  output logic [DATA_W-1:0]          sample,
  output logic                       sample_valid,
  output logic [DATA_W-1:0]          avg,
  output logic                       avg_valid,
  output logic                       overrun,
  output logic                       busy,
  output logic [DATA_W-1:0]          win_min,
  output logic [DATA_W-1:0]          win_max
);
  localparam int TW = $clog2(POLL_DIV);
  localparam int LW = $clog2(READ_LATENCY + 1);
  localparam int AW = DATA_W + AVG_LOG2;
  localparam int CW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);
  typedef enum logic [1:0] {IDLE, REQ, LAT} state_t;
  state_t            state;
  logic [TW-1:0]     timer;
  logic [LW-1:0]     lat;
  logic [AW-1:0]     acc;
  logic [AW-1:0]     sum;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] din;
  logic              tick;
  logic              cap;
  logic              last;
  logic              unused_hi;
  assign din         = avm.readdata[DATA_W-1:0];
  assign unused_hi   = ^avm.readdata[31:DATA_W];
  assign tick        = enable && timer == '0;
  assign cap         = state == LAT && lat == '0;
  assign last        = cnt == LAST;
  assign sum         = acc + AW'(din);
  assign busy        = state != IDLE;
  assign avm.address = '0;
  // poll timer: held at reload while disabled, free-runs and ticks every POLL_DIV clocks when enabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) timer <= TW'(POLL_DIV - 1);
    else timer <= (!enable || timer == '0) ? TW'(POLL_DIV - 1) : timer - TW'(1);
  end
  // read FSM: issue one read per tick, wait out the fixed latency, capture the sample; flag dropped ticks
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      avm.read     <= 1'b0;
      lat          <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (!enable) overrun <= 1'b0;
      else if (tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (tick) begin
          state    <= REQ;
          avm.read <= 1'b1;
        end
        REQ: if (!avm.waitrequest) begin
          state    <= LAT;
          avm.read <= 1'b0;
          lat      <= LW'(READ_LATENCY - 1);
        end
        LAT: if (cap) begin
          state        <= IDLE;
          sample       <= din;
          sample_valid <= 1'b1;
        end else lat <= lat - LW'(1);
        default: state <= IDLE;
      endcase
    end
  end
  // window accumulator: sum 2^AVG_LOG2 samples, emit truncated mean, drop partial window when disabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc       <= '0;
      cnt       <= '0;
      avg       <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (cap) begin
        if (last) begin
          avg       <= DATA_W'(sum >> AVG_LOG2);
          avg_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + CW'(1);
        end
      end else if (state == IDLE && !enable) begin
        acc <= '0;
        cnt <= '0;
      end
    end
  end
`ifdef LTC5548_POLL_MINMAX_EN
  logic [DATA_W-1:0] cur_min;
  logic [DATA_W-1:0] cur_max;
  logic [DATA_W-1:0] nxt_min;
  logic [DATA_W-1:0] nxt_max;
  assign nxt_min = (cnt == '0 || din < cur_min) ? din : cur_min;
  assign nxt_max = (cnt == '0 || din > cur_max) ? din : cur_max;
  // window extremes: seeded by each window's first sample, published alongside the average
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_min <= '0;
      cur_max <= '0;
      win_min <= '0;
      win_max <= '0;
    end else if (cap) begin
      cur_min <= nxt_min;
      cur_max <= nxt_max;
      if (last) begin
        win_min <= nxt_min;
        win_max <= nxt_max;
      end
    end else if (state == IDLE && !enable) begin
      cur_min <= '0;
      cur_max <= '0;
      win_min <= '0;
      win_max <= '0;
    end
  end
`else
  assign win_min = '0;
  assign win_max = '0;
`endif
endmodule

// File: tb/tb_ltc5548_pio_poll_master.sv
// tb_ltc5548_pio_poll_master: directed bench with a latency-1 slave model for ltc5548_pio_poll_master
module tb_ltc5548_pio_poll_master;
  localparam int PD = 8;
  localparam int RL = 1;
  localparam int AL = 2;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic [11:0] sample, avg, win_min, win_max;
  logic sample_valid, avg_valid, overrun, busy;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int prev_acc = 0;
  logic [11:0] next_data = '0;
  logic [19:0] hi = '0;
  always #5 clk = ~clk;
  ltc5548_pio_poll_master_if bus();
  ltc5548_pio_poll_master #(.DATA_W(12), .POLL_DIV(PD), .READ_LATENCY(RL), .AVG_LOG2(AL)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .avm(bus),
    .sample(sample), .sample_valid(sample_valid), .avg(avg), .avg_valid(avg_valid),
    .overrun(overrun), .busy(busy), .win_min(win_min), .win_max(win_max)
  );
  // slave model: registered readdata one clock after an accepted read; records accept cycles
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.read && !bus.waitrequest) begin
      bus.readdata <= {hi, next_data};
      prev_acc     <= acc_cyc;
      acc_cyc      <= cyc;
    end
  end
  task automatic chk(input logic [31:0] got, input logic [31:0] exp, input string tag);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic get_sample(input logic [11:0] es, input logic eav, input logic [11:0] eavg, input string tag);
    int k = 0;
    @(negedge clk);
    while (!sample_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(32'(sample_valid), 1, {tag, "_valid"});
    chk(32'(sample), 32'(es), {tag, "_sample"});
    chk(32'(cyc - acc_cyc), 32'(1 + RL), {tag, "_latency"});
    chk(32'(avg_valid), 32'(eav), {tag, "_avg_valid"});
    if (eav) chk(32'(avg), 32'(eavg), {tag, "_avg"});
  endtask
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask
  initial begin
    int k;
    int av_cnt;
    logic ok;
    bus.waitrequest = 1'b0;
    idle_cycles(2);
    chk(32'({bus.read, sample_valid, avg_valid, overrun, busy, sample, avg, bus.address}), 0, "reset_outputs");
    chk(32'({win_min, win_max}), 0, "reset_minmax");
    reset_n = 1'b1;
    idle_cycles(2);
    chk(32'(bus.read), 0, "idle_no_read");
    enable = 1'b1;
    next_data = 12'h100; get_sample(12'h100, 1'b0, '0, "t1_s0");
    next_data = 12'h102; get_sample(12'h102, 1'b0, '0, "t1_s1");
    chk(32'(acc_cyc - prev_acc), PD, "t1_spacing1");
    next_data = 12'h104; get_sample(12'h104, 1'b0, '0, "t1_s2");
    chk(32'(acc_cyc - prev_acc), PD, "t1_spacing2");
    next_data = 12'h106; get_sample(12'h106, 1'b1, 12'h103, "t1_s3");
    chk(32'(acc_cyc - prev_acc), PD, "t1_spacing3");
`ifdef LTC5548_POLL_MINMAX_EN
    chk(32'({win_min, win_max}), 32'({12'h100, 12'h106}), "t1_minmax");
`endif
    next_data = 12'h001; get_sample(12'h001, 1'b0, '0, "t2_s0");
    next_data = 12'h001; get_sample(12'h001, 1'b0, '0, "t2_s1");
    next_data = 12'h001; get_sample(12'h001, 1'b0, '0, "t2_s2");
    next_data = 12'h002; get_sample(12'h002, 1'b1, 12'h001, "t2_s3");
`ifdef LTC5548_POLL_MINMAX_EN
    chk(32'({win_min, win_max}), 32'({12'h001, 12'h002}), "t2_minmax");
`else
    chk(32'({win_min, win_max}), 0, "t2_minmax_off");
`endif
    hi = 20'hABCDE;
    next_data = 12'hFFF;
    get_sample(12'hFFF, 1'b0, '0, "t3_s0");
    get_sample(12'hFFF, 1'b0, '0, "t3_s1");
    get_sample(12'hFFF, 1'b0, '0, "t3_s2");
    get_sample(12'hFFF, 1'b1, 12'hFFF, "t3_s3");
    hi = '0;
    enable = 1'b0;
    idle_cycles(3);
    bus.waitrequest = 1'b1;
    next_data = 12'h055;
    enable = 1'b1;
    k = 0;
    while (!bus.read && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(32'(bus.read), 1, "t4_read_seen");
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ok &= bus.read && bus.address == 2'd0 && !sample_valid;
    end
    chk(32'(ok), 1, "t4_stall_stable");
    chk(32'(overrun), 1, "t4_overrun_set");
    bus.waitrequest = 1'b0;
    get_sample(12'h055, 1'b0, '0, "t4_s0");
    enable = 1'b0;
    idle_cycles(2);
    chk(32'(overrun), 0, "t4_overrun_clear");
    chk(32'(busy), 0, "t4_busy_low");
    enable = 1'b1;
    next_data = 12'h050;
    get_sample(12'h050, 1'b0, '0, "t5_p0");
    get_sample(12'h050, 1'b0, '0, "t5_p1");
    enable = 1'b0;
    av_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      av_cnt += int'(avg_valid);
    end
    chk(32'(av_cnt), 0, "t5_no_avg");
    chk(32'(avg), 32'h0FFF, "t5_avg_held");
    enable = 1'b1;
    next_data = 12'h010;
    get_sample(12'h010, 1'b0, '0, "t5_s0");
    get_sample(12'h010, 1'b0, '0, "t5_s1");
    get_sample(12'h010, 1'b0, '0, "t5_s2");
    get_sample(12'h010, 1'b1, 12'h010, "t5_s3");
    next_data = 12'h0AA;
    k = 0;
    @(negedge clk);
    while (!bus.read && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(32'(bus.read), 1, "t6_read_seen");
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk(32'({bus.read, sample_valid, avg_valid, overrun, busy, sample, avg, bus.address}), 0, "t6_reset_outputs");
    @(negedge clk);
    chk(32'({sample_valid, bus.read, busy}), 0, "t6_no_capture");
    next_data = 12'h0BB;
    reset_n = 1'b1;
    k = 0;
    while (!bus.read && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(32'(k), PD, "t6_restart_delay");
    get_sample(12'h0BB, 1'b0, '0, "t6_s0");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
